// File: rtl/port_io_pkg.sv
// Shared register offsets, CTRL bit positions and bus FSM states for the port I/O responder.
// No logic; no latency or backpressure of its own.
package port_io_pkg;

   localparam logic [2:0] OFS_OUT   = 3'd0;
   localparam logic [2:0] OFS_IN    = 3'd1;
   localparam logic [2:0] OFS_LOAD  = 3'd2;
   localparam logic [2:0] OFS_CTRL  = 3'd3;
   localparam logic [2:0] OFS_COUNT = 3'd4;
   localparam logic [2:0] OFS_STAT  = 3'd5;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_IE  = 1;
   localparam int CTRL_AR  = 2;
   localparam int CTRL_EXP = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } bus_state_t;

endpackage

// File: rtl/port_io_timer.sv
// Interval timer: prescaler, down-counter with optional auto-reload, sticky expiry flag.
// Register writes take effect at the strobe edge; strobes are never stalled.
// A CTRL write that clears EN in the same cycle as a tick suppresses that tick.
module port_io_timer
   import port_io_pkg::*;
#(
   parameter int PRESCALE = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_wr,
   input  logic       ctrl_wr,
   input  logic       exp_clr,
   input  logic [7:0] wr_dat,
   output logic [7:0] load_q,
   output logic [7:0] count_q,
   output logic [2:0] ctrl_q,
   output logic       exp_q
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_q;
   logic          en_q;
   logic          ie_q;
   logic          ar_q;
   logic          stop_wr;
   logic          tick;
   logic          expire;

   always_comb begin
      stop_wr = ctrl_wr & ~wr_dat[CTRL_EN];
      tick    = en_q & (presc_q == PRESC_MAX) & ~stop_wr & ~load_wr;
      expire  = tick & (count_q == 8'h00);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         presc_q <= '0;
         load_q  <= 8'h00;
         count_q <= 8'h00;
         en_q    <= 1'b0;
         ie_q    <= 1'b0;
         ar_q    <= 1'b0;
         exp_q   <= 1'b0;
      end else begin
         if (load_wr) begin
            presc_q <= '0;
         end else if (en_q && !stop_wr) begin
            presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
         end

         if (load_wr) begin
            load_q  <= wr_dat;
            count_q <= wr_dat;
         end else if (tick) begin
            if (count_q != 8'h00) begin
               count_q <= count_q - 8'd1;
            end else begin
               count_q <= ar_q ? load_q : 8'h00;
            end
         end

         // setting the flag takes priority over any clear in the same cycle
         if (expire) begin
            exp_q <= 1'b1;
         end else if (exp_clr) begin
            exp_q <= 1'b0;
         end

         if (ctrl_wr) begin
            en_q <= wr_dat[CTRL_EN];
            ie_q <= wr_dat[CTRL_IE];
            ar_q <= wr_dat[CTRL_AR];
         end else if (expire && !ar_q) begin
            en_q <= 1'b0;
         end
      end
   end

   assign ctrl_q = {ar_q, ie_q, en_q};

endmodule

// File: rtl/port_io_responder.sv
// Port-bus responder with GPIO latch, synchronised GPIO input and interval timer (PORT_IO_RDWAIT_EN adds a read wait state).
// Latency: ack one cycle after the sampling edge, reads two cycles when PORT_IO_RDWAIT_EN is defined.
// Backpressure: requests are ignored while a response is in flight, so at most one ack per two cycles.
module port_io_responder
   import port_io_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR = 8'h00,
   parameter int         PRESCALE  = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       port_cyc_i,
   input  logic       port_stb_i,
   input  logic       port_we_i,
   input  logic [7:0] port_adr_i,
   input  logic [7:0] port_dat_i,
   output logic [7:0] port_dat_o,
   output logic       port_ack_o,
   input  logic [7:0] gpio_i,
   output logic [7:0] gpio_o,
   output logic       int_req_o,
   input  logic       int_ack_i
);

   bus_state_t state_q;
   bus_state_t state_d;
   logic       req;
   logic       hit;
   logic       wr_en;
   logic       cap_rd;
   logic [2:0] ofs;
   logic [2:0] rd_ofs;
   logic [7:0] out_q;
   logic [7:0] sync1_q;
   logic [7:0] sync2_q;
   logic [7:0] dat_q;
   logic [7:0] rd_mux;
   logic [7:0] load_q;
   logic [7:0] count_q;
   logic [2:0] ctrl_q;
   logic       exp_q;
   logic       load_wr;
   logic       ctrl_wr;
   logic       exp_clr;

   assign req = port_cyc_i & port_stb_i;
   assign hit = (port_adr_i[7:3] == BASE_ADDR[7:3]);
   assign ofs = port_adr_i[2:0];

   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      cap_rd  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && hit) begin
               state_d = ACK;
               if (port_we_i) begin
                  wr_en = 1'b1;
               end else begin
`ifdef PORT_IO_RDWAIT_EN
                  state_d = WAIT;
`else
                  cap_rd  = 1'b1;
`endif
               end
            end
         end
         WAIT: begin
            cap_rd  = 1'b1;
            state_d = ACK;
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef PORT_IO_RDWAIT_EN
   // the bus only holds the address for the sampling edge
   logic [2:0] ofs_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ofs_q <= 3'd0;
      end else if (state_q == IDLE && req && hit) begin
         ofs_q <= ofs;
      end
   end

   assign rd_ofs = ofs_q;
`else
   assign rd_ofs = ofs;
`endif

   always_comb begin
      load_wr = wr_en & (ofs == OFS_LOAD);
      ctrl_wr = wr_en & (ofs == OFS_CTRL);
      exp_clr = int_ack_i | (wr_en & (ofs == OFS_STAT) & port_dat_i[CTRL_EXP]);
   end

   always_comb begin
      rd_mux = 8'h00;
      case (rd_ofs)
         OFS_OUT:   rd_mux = out_q;
         OFS_IN:    rd_mux = sync2_q;
         OFS_LOAD:  rd_mux = load_q;
         OFS_CTRL:  rd_mux = {exp_q, 4'b0000, ctrl_q};
         OFS_COUNT: rd_mux = count_q;
         OFS_STAT:  rd_mux = {exp_q, 7'b0000000};
         default:   rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         out_q   <= 8'h00;
         sync1_q <= 8'h00;
         sync2_q <= 8'h00;
         dat_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         sync1_q <= gpio_i;
         sync2_q <= sync1_q;
         if (wr_en && ofs == OFS_OUT) begin
            out_q <= port_dat_i;
         end
         if (cap_rd) begin
            dat_q <= rd_mux;
         end
      end
   end

   port_io_timer #(
      .PRESCALE (PRESCALE)
   ) u_timer (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_wr (load_wr),
      .ctrl_wr (ctrl_wr),
      .exp_clr (exp_clr),
      .wr_dat  (port_dat_i),
      .load_q  (load_q),
      .count_q (count_q),
      .ctrl_q  (ctrl_q),
      .exp_q   (exp_q)
   );

   assign port_ack_o = (state_q == ACK);
   assign port_dat_o = dat_q;
   assign gpio_o     = out_q;
   assign int_req_o  = exp_q & ctrl_q[CTRL_IE];

endmodule

// File: tb/tb_port_io_responder.sv
// Randomised bench for port_io_responder: bus register access, GPIO paths, timer expiry and interrupt handshake.
module tb_port_io_responder;
   import port_io_pkg::*;

   localparam logic [7:0] BASE = 8'h40;
   localparam int         P    = 4;
`ifdef PORT_IO_RDWAIT_EN
   localparam int RD_LAT = 2;
`else
   localparam int RD_LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       cyc, stb, we;
   logic [7:0] adr, wdat;
   logic [7:0] port_dat_o;
   logic       port_ack_o;
   logic [7:0] gpio_i, gpio_o;
   logic       int_req_o, int_ack;

   port_io_responder #(.BASE_ADDR(BASE), .PRESCALE(P)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .port_cyc_i (cyc),
      .port_stb_i (stb),
      .port_we_i  (we),
      .port_adr_i (adr),
      .port_dat_i (wdat),
      .port_dat_o (port_dat_o),
      .port_ack_o (port_ack_o),
      .gpio_i     (gpio_i),
      .gpio_o     (gpio_o),
      .int_req_o  (int_req_o),
      .int_ack_i  (int_ack)
   );

   always #5 clk = ~clk;

   // index of the next rising edge when read at a falling edge
   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // timer reference: started with EN at edge t_w from COUNT=LOAD and a cleared prescaler
   int t_w, t_last_clr;
   int t_L;
   bit t_ar;

   function automatic void tmodel(input int e, output logic [7:0] cnt, output logic en, output logic ex);
      int t, nexp, lastx;
      t = (e - t_w) / P;
      if (t_ar) begin
         nexp  = t / (t_L + 1);
         cnt   = 8'(t_L - (t % (t_L + 1)));
         en    = 1'b1;
         lastx = t_w + nexp * (t_L + 1) * P;
      end else if (t <= t_L) begin
         nexp  = 0;
         cnt   = 8'(t_L - t);
         en    = 1'b1;
         lastx = 0;
      end else begin
         nexp  = 1;
         cnt   = 8'h00;
         en    = 1'b0;
         lastx = t_w + (t_L + 1) * P;
      end
      ex = (nexp > 0) && (lastx >= t_last_clr);
   endfunction

   task automatic bus_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                           output logic [7:0] rdat, output int edge_n);
      int lat;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
      edge_n = cyc_cnt;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      lat = 0;
      for (int i = 1; i <= 4; i++) begin
         if (port_ack_o) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
      rdat = port_dat_o;
      check_eq("ack_latency", lat, w ? 1 : RD_LAT);
      if (lat != 0) begin
         @(negedge clk);
         check_eq("ack_one_cycle", {31'd0, port_ack_o}, 0);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d, output int edge_n);
      logic [7:0] dummy;
      bus_xfer(1'b1, a, d, dummy, edge_n);
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d, output int edge_n);
      bus_xfer(1'b0, a, 8'h00, d, edge_n);
   endtask

   task automatic check_req(input string tag);
      logic [7:0] c; logic en, ex;
      tmodel(cyc_cnt - 1, c, en, ex);
      check_eq(tag, {31'd0, int_req_o}, {31'd0, ex});
   endtask

   task automatic pulse_ack();
      int_ack = 1'b1;
      t_last_clr = cyc_cnt;
      @(negedge clk);
      int_ack = 1'b0;
      check_req("int_req_after_ack");
   endtask

   task automatic wait_to(input int n);
      while (cyc_cnt < n) @(negedge clk);
   endtask

   task automatic rd_timer();
      logic [7:0] d, c; logic en, ex; int n;
      rd(BASE + 8'(OFS_COUNT), d, n);
      tmodel(n + RD_LAT - 2, c, en, ex);
      check_eq("count", d, c);
      rd(BASE + 8'(OFS_CTRL), d, n);
      tmodel(n + RD_LAT - 2, c, en, ex);
      check_eq("ctrl", d, {ex, 4'b0000, t_ar, 1'b1, en});
      rd(BASE + 8'(OFS_STAT), d, n);
      tmodel(n + RD_LAT - 2, c, en, ex);
      check_eq("stat", d, {ex, 7'b0000000});
      check_req("int_req");
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [7:0] v, g, d, m_out;
      int n, acks;

      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 8'h00; wdat = 8'h00;
      gpio_i = 8'h00; int_ack = 1'b0;
      t_w = 0; t_last_clr = 0; t_L = 0; t_ar = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_ack", {31'd0, port_ack_o}, 0);
      check_eq("rst_dat", port_dat_o, 8'h00);
      check_eq("rst_gpio_o", gpio_o, 8'h00);
      check_eq("rst_int_req", {31'd0, int_req_o}, 0);
      rst = 1'b0;

      wr(BASE + 8'(OFS_OUT), 8'hA5, n);
      check_eq("gpio_o_a5", gpio_o, 8'hA5);
      rd(BASE + 8'(OFS_OUT), d, n);
      check_eq("rd_out_a5", d, 8'hA5);
      m_out = 8'hA5;

      for (int i = 0; i < 8; i++) begin
         v = 8'($urandom);
         g = 8'($urandom);
         gpio_i = g;
         wr(BASE + 8'(OFS_OUT), v, n);
         m_out = v;
         check_eq("gpio_o", gpio_o, m_out);
         rd(BASE + 8'(OFS_IN), d, n);
         check_eq("rd_in", d, g);
         wr(BASE + 8'($urandom_range(6, 7)), 8'($urandom), n);
         wr(BASE + 8'(OFS_IN), ~g, n);
         rd(BASE + 8'($urandom_range(6, 7)), d, n);
         check_eq("rd_unused", d, 8'h00);
         rd(BASE + 8'(OFS_IN), d, n);
         check_eq("rd_in_after_ro_write", d, g);
         rd(BASE + 8'(OFS_OUT), d, n);
         check_eq("rd_out", d, m_out);
      end

      // requests outside the window are held for 10 cycles and must never be acknowledged
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         cyc = 1'b1; stb = 1'b1; we = 1'b1;
         adr = (k == 0) ? BASE + 8'h08 : BASE - 8'h01;
         wdat = ~m_out;
         acks = 0;
         repeat (10) begin
            @(negedge clk);
            if (port_ack_o) acks++;
         end
         cyc = 1'b0; stb = 1'b0;
         check_eq("out_of_window_ack", acks, 0);
         check_eq("out_of_window_gpio", gpio_o, m_out);
      end

      for (int r = 0; r < 5; r++) begin
         t_L  = (r == 0) ? 2 : $urandom_range(0, 4);
         t_ar = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         wr(BASE + 8'(OFS_CTRL), 8'h00, n);
         wr(BASE + 8'(OFS_STAT), 8'h80, n);
         wr(BASE + 8'(OFS_LOAD), 8'(t_L), n);
         wr(BASE + 8'(OFS_CTRL), {5'b00000, t_ar, 2'b11}, t_w);
         t_last_clr = t_w;
         if (r == 0) begin
            wait_to(t_w + 12);
            check_eq("int_req_before_12", {31'd0, int_req_o}, 0);
            @(negedge clk);
            check_eq("int_req_at_12", {31'd0, int_req_o}, 1);
            pulse_ack();
            rd_timer();
            wait_to(t_w + 24);
            pulse_ack();
            check_eq("ack_on_expiry_keeps_req", {31'd0, int_req_o}, 1);
         end
         if (r == 1) begin
            wait_to(t_w + (t_L + 1) * P + 4);
            rd_timer();
            pulse_ack();
            check_eq("single_expiry_cleared", {31'd0, int_req_o}, 0);
         end
         repeat (3) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            rd_timer();
         end
      end

      // reset while an ack is showing
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 8'(OFS_OUT); wdat = 8'hC3;
      @(posedge clk);
      #2;
      check_eq("pre_reset_ack", {31'd0, port_ack_o}, 1);
      rst = 1'b1;
      #1;
      check_eq("async_rst_ack", {31'd0, port_ack_o}, 0);
      check_eq("async_rst_gpio", gpio_o, 8'h00);
      check_eq("async_rst_int", {31'd0, int_req_o}, 0);
      @(negedge clk);
      rst = 1'b0;
      cyc = 1'b0; stb = 1'b0;

      // a write sampled during reset is discarded
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 8'(OFS_OUT); wdat = 8'h77;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rst_discard_gpio", gpio_o, 8'h00);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      rst = 1'b0;

      wr(BASE + 8'(OFS_OUT), 8'h5A, n);
      check_eq("post_reset_gpio", gpio_o, 8'h5A);
      rd(BASE + 8'(OFS_COUNT), d, n);
      check_eq("post_reset_count", d, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
